adc_spi_reader: RTL and testbench

Serial ADC front end. It produces the parallel `data`/`data_ready` sample stream that the ADC summing accumulator consumes.
- On each `start` pulse it runs one conversion on an external SPI ADC: a CNV pulse, a conversion wait, then a DATA_WIDTH-bit MSB-first readout.
- It then presents the sample with a single-cycle `data_ready` strobe.
- Sits between the ADC pins and the accumulator/pulse-sequencer logic.

---
 rtl/adc_reader_pkg.sv | 29 ++
 rtl/adc_reader_sclk_gen.sv | 42 ++++
 rtl/adc_spi_reader.sv | 133 +++++++++++++
 tb/tb_adc_spi_reader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_reader_pkg.sv
// Shared types and helpers for the serial ADC reader: FSM state encoding,
// default geometry and counter-width helpers used by the reader and its
// serial-clock generator.
package adc_reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEFAULT_DATA_WIDTH  = 16;
  localparam int DEFAULT_CLK_DIV     = 2;
  localparam int DEFAULT_CONV_CYCLES = 50;

  // Length of the readout window: DATA_WIDTH full sclk periods.
  function automatic int shift_cycles(input int data_width, input int clk_div);
    return 2 * clk_div * data_width;
  endfunction

  localparam int SHIFT_CYCLES = shift_cycles(DEFAULT_DATA_WIDTH, DEFAULT_CLK_DIV);

  // Bits needed for a counter that runs 0 .. count-1 (at least one bit).
  function automatic int cnt_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/adc_reader_sclk_gen.sv
// Serial clock generator for the ADC readout. While enabled, sclk starts low
// and toggles every CLK_DIV clk cycles; rise is a one-cycle strobe that is
// high during the first clk cycle in which sclk is high. Disabling returns
// sclk low and restarts the divider so every readout begins identically.
module sclk_gen
  import adc_reader_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise
);

  localparam int DIV_W = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Half-period divider; rise is registered together with the low->high toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
      rise    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
      rise    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
      rise    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      rise    <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// Serial ADC front end: on each start pulse, pulses CNV for the conversion
// time, then clocks DATA_WIDTH bits MSB-first out of the ADC and presents
// the sample on data with a one-cycle data_ready strobe. A start that lands
// while a conversion is in flight is dropped and flagged in sticky overrun.
module adc_spi_reader
  import adc_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int CLK_DIV     = DEFAULT_CLK_DIV,
  parameter int CONV_CYCLES = DEFAULT_CONV_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clr_overrun,
  input  logic                  adc_sdo,
  output logic                  adc_cnv,
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_ready,
  output logic                  busy,
  output logic                  overrun
);

  localparam int SHIFT_LEN = shift_cycles(DATA_WIDTH, CLK_DIV);
  localparam int CNT_MAX   = (SHIFT_LEN > CONV_CYCLES) ? SHIFT_LEN : CONV_CYCLES;
  localparam int CNT_W     = cnt_width(CNT_MAX);
  localparam int BIT_W     = cnt_width(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_LEN - 1);
  localparam logic [BIT_W-1:0] BITS_ALL   = BIT_W'(DATA_WIDTH);

  state_t                state;
  logic [CNT_W-1:0]      cycle_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  sclk_en;
  logic                  sclk_rise;
  logic                  take_bit;

  // The divider only runs during readout, so sclk idles low with CS high.
  assign sclk_en = (state == SHIFT);

  // Never take more than DATA_WIDTH bits, even if the window were longer.
  assign take_bit   = sclk_rise && (bit_cnt != BITS_ALL);
  assign shift_next = take_bit ? {shift_reg[DATA_WIDTH-2:0], adc_sdo} : shift_reg;

  sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk (clk),
    .rst (rst),
    .en  (sclk_en),
    .sclk(adc_sclk),
    .rise(sclk_rise)
  );

  // Conversion sequencer with registered pin outputs, sample and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cycle_cnt  <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data       <= '0;
      data_ready <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      adc_cnv    <= 1'b0;
      adc_cs_n   <= 1'b1;
    end else begin
      data_ready <= 1'b0;

      if (start && (state != IDLE)) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= CONVERT;
            adc_cnv   <= 1'b1;
            busy      <= 1'b1;
            cycle_cnt <= '0;
            bit_cnt   <= '0;
          end
        end

        CONVERT: begin
          if (cycle_cnt == CONV_LAST) begin
            state     <= SHIFT;
            adc_cnv   <= 1'b0;
            adc_cs_n  <= 1'b0;
            cycle_cnt <= '0;
          end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end

        SHIFT: begin
          shift_reg <= shift_next;
          if (take_bit) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (cycle_cnt == SHIFT_LAST) begin
            state      <= DONE;
            data       <= shift_next;
            data_ready <= 1'b1;
            adc_cs_n   <= 1'b1;
            cycle_cnt  <= '0;
          end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed testbench for adc_spi_reader with default geometry
// (16 bits, CLK_DIV 2, CONV_CYCLES 50): start-to-strobe latency of 115
// cycles, pin timing, overrun handling and asynchronous reset mid-readout.
`timescale 1ns/1ps
module tb_adc_spi_reader;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          clr_overrun;
  logic          adc_sdo;
  logic          adc_cnv;
  logic          adc_cs_n;
  logic          adc_sclk;
  logic [DW-1:0] data;
  logic          data_ready;
  logic          busy;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_spi_reader #(
    .DATA_WIDTH (DW),
    .CLK_DIV    (2),
    .CONV_CYCLES(50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .clr_overrun(clr_overrun),
    .adc_sdo    (adc_sdo),
    .adc_cnv    (adc_cnv),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .data       (data),
    .data_ready (data_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  // ADC model: presents the MSB when selected, advances one bit per sclk fall.
  logic [DW-1:0] adc_word = '0;
  logic [DW-1:0] adc_shifted;
  int            bit_idx = 0;

  always @(negedge adc_sclk or posedge adc_cs_n) begin
    if (adc_cs_n === 1'b1) bit_idx <= 0;
    else                   bit_idx <= bit_idx + 1;
  end

  assign adc_shifted = adc_word << bit_idx;
  assign adc_sdo     = (adc_cs_n === 1'b0) && adc_shifted[DW-1];

  // Pin monitor sampled on the falling clk edge: cumulative counters only.
  int   mon_cyc   = 0;
  int   cnv_hi    = 0;
  int   cs_lo     = 0;
  int   rises     = 0;
  int   gap_bad   = 0;
  int   sclk_viol = 0;
  int   strobes   = 0;
  int   last_rise = -1;
  logic sclk_prev = 1'b0;

  always @(negedge clk) begin
    mon_cyc <= mon_cyc + 1;
    if (adc_cnv === 1'b1) cnv_hi <= cnv_hi + 1;
    if (adc_cs_n === 1'b0) cs_lo <= cs_lo + 1;
    if (adc_sclk === 1'b1 && adc_cs_n !== 1'b0) sclk_viol <= sclk_viol + 1;
    if (data_ready === 1'b1) strobes <= strobes + 1;
    if (adc_cs_n !== 1'b0) begin
      last_rise <= -1;
    end else if (adc_sclk === 1'b1 && sclk_prev === 1'b0) begin
      rises <= rises + 1;
      if (last_rise >= 0 && (mon_cyc - last_rise) != 4) gap_bad <= gap_bad + 1;
      last_rise <= mon_cyc;
    end
    sclk_prev <= adc_sclk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock edge, then settle 1 ns so registered outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion with starts 120 cycles apart; checks data, latency and pins.
  task automatic applyStimulus(input logic [DW-1:0] word, input string tag,
                               output logic [DW-1:0] got);
    int lat;
    int c0, s0, r0, g0, v0, st0;
    lat = 0;
    got = '0;
    c0  = cnv_hi;
    s0  = cs_lo;
    r0  = rises;
    g0  = gap_bad;
    v0  = sclk_viol;
    st0 = strobes;
    adc_word = word;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j < 120; j++) begin
      tick();
      // Sampling just after edge E+j observes cycle E+j+1.
      if (data_ready === 1'b1 && lat == 0) begin
        lat = j + 1;
        got = data;
      end
    end
    checkOutput({tag, " latency"}, lat, 115);
    checkOutput({tag, " data"}, got, word);
    checkOutput({tag, " cnv_cycles"}, cnv_hi - c0, 50);
    checkOutput({tag, " cs_low_cycles"}, cs_lo - s0, 64);
    checkOutput({tag, " sclk_rises"}, rises - r0, 16);
    checkOutput({tag, " sclk_gap_bad"}, gap_bad - g0, 0);
    checkOutput({tag, " sclk_high_no_cs"}, sclk_viol - v0, 0);
    checkOutput({tag, " strobe_count"}, strobes - st0, 1);
    checkOutput({tag, " overrun"}, overrun, 1'b0);
    checkOutput({tag, " busy_after"}, busy, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] pass1 [5];
    logic [DW-1:0] pass2 [5];
    logic [DW-1:0] got;
    int            sum;
    int            seen;
    int            st0;

    pass1 = '{16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
    pass2 = '{16'h0002, 16'h0003, 16'h0004, 16'hFFF8, 16'h0006};

    rst         = 1'b1;
    start       = 1'b0;
    clr_overrun = 1'b0;
    #1;
    checkOutput("reset data", data, 16'h0000);
    checkOutput("reset data_ready", data_ready, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset overrun", overrun, 1'b0);
    checkOutput("reset cnv", adc_cnv, 1'b0);
    checkOutput("reset cs_n", adc_cs_n, 1'b1);
    checkOutput("reset sclk", adc_sclk, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    $display("[TB] back-to-back samples 2..6");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(pass1[i], $sformatf("p1[%0d]", i), got);
    end

    $display("[TB] accumulator stream 2,3,4,FFF8,6");
    sum = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(pass2[i], $sformatf("p2[%0d]", i), got);
      sum += int'(signed'(got));
    end
    checkOutput("accum sum", sum, 32'd7);

    $display("[TB] overrun handling");
    seen = 0;
    adc_word = 16'h1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 235; j++) begin
      start       = (j == 10) || (j == 114) || (j == 116);
      clr_overrun = (j == 200);
      if (j == 116) adc_word = 16'h8001;
      tick();
      start       = 1'b0;
      clr_overrun = 1'b0;
      if (data_ready === 1'b1) seen++;
      if (j == 9)   checkOutput("ovr before stray start", overrun, 1'b0);
      if (j == 10)  checkOutput("ovr set by stray start", overrun, 1'b1);
      if (j == 114) checkOutput("ovr first strobe", data_ready, 1'b1);
      if (j == 114) checkOutput("ovr first data", data, 16'h1234);
      if (j == 115) checkOutput("ovr done->idle busy", busy, 1'b0);
      if (j == 116) checkOutput("ovr restart busy", busy, 1'b1);
      if (j == 116) checkOutput("ovr restart cnv", adc_cnv, 1'b1);
      if (j == 199) checkOutput("ovr still sticky", overrun, 1'b1);
      if (j == 200) checkOutput("ovr cleared", overrun, 1'b0);
      if (j == 230) checkOutput("ovr second strobe", data_ready, 1'b1);
      if (j == 230) checkOutput("ovr second data", data, 16'h8001);
    end
    checkOutput("ovr strobe count", seen, 2);

    $display("[TB] asynchronous reset mid-readout");
    adc_word = 16'h5A5A;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (80) tick();
    checkOutput("rst pre cs_n", adc_cs_n, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst async cs_n", adc_cs_n, 1'b1);
    checkOutput("rst async sclk", adc_sclk, 1'b0);
    checkOutput("rst async cnv", adc_cnv, 1'b0);
    checkOutput("rst async busy", busy, 1'b0);
    checkOutput("rst async data", data, 16'h0000);
    checkOutput("rst async data_ready", data_ready, 1'b0);
    st0 = strobes;
    repeat (3) tick();
    rst = 1'b0;
    repeat (60) tick();
    checkOutput("rst no strobe", strobes - st0, 0);
    checkOutput("rst data held 0", data, 16'h0000);
    applyStimulus(16'hC3A5, "post-rst", got);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
